// File: rtl/riscv_alu_ctrl.sv
// Execute-stage issue controller: decodes RV32I into ALU ops, drives the external ALU
// from the S1 registers and captures the result plus writeback/redirect info in S2.
module riscv_alu_ctrl #(
    parameter int XLEN        = 32,
    parameter int CHECK_ALIGN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      alu_op,
    input  logic            alu_flag,
    input  logic [XLEN-1:0] alu_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd_addr,
    output logic [XLEN-1:0] out_rd_data,
    output logic            out_rd_we,
    output logic            out_br_taken,
    output logic [XLEN-1:0] out_br_target,
    output logic            out_illegal,
    output logic            out_misaligned
);
    localparam logic [4:0] OP_ADD = 5'b00000;

    typedef struct packed {
        logic [4:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] tgt;
        logic [4:0]      rd;
        logic            br;
        logic            jmp;
        logic            we;
        logic            ill;
    } s1_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] tgt;
        logic [4:0]      rd;
        logic            we;
        logic            taken;
        logic            ill;
        logic            mis;
    } s2_t;

    logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    s1_t  s1_q, s1_d, dec;
    s2_t  s2_q, s2_d;
    logic s1_adv, accept, taken, legal;

    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i, imm_b, imm_u, imm_j, shamt, jalr_sum;

    assign opc   = in_instr[6:0];
    assign rd    = in_instr[11:7];
    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_b = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    // Shift immediates present only the shift amount, so alu_b never carries the funct7 bits.
    assign shamt    = {{(XLEN-5){1'b0}}, in_instr[24:20]};
    assign jalr_sum = in_rs1 + imm_i;

    always_comb begin
        dec    = '0;
        dec.op = OP_ADD;
        dec.pc = in_pc;
        dec.rd = rd;
        legal  = 1'b1;
        case (opc)
            7'b0110011: begin
                dec.op = {1'b0, f7[5], f3};
                dec.a  = in_rs1;
                dec.b  = in_rs2;
                legal  = (f7 == 7'b0) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            end
            7'b0010011: begin
                dec.op = {2'b00, f3};
                dec.a  = in_rs1;
                dec.b  = imm_i;
                if (f3 == 3'b001) begin
                    dec.b = shamt;
                    legal = (f7 == 7'b0);
                end else if (f3 == 3'b101) begin
                    dec.op = {1'b0, in_instr[30], f3};
                    dec.b  = shamt;
                    legal  = (f7 == 7'b0) || (f7 == 7'b0100000);
                end
            end
            7'b1100011: begin
                dec.op  = {2'b11, f3};
                dec.a   = in_rs1;
                dec.b   = in_rs2;
                dec.br  = 1'b1;
                dec.tgt = in_pc + imm_b;
                legal   = (f3 != 3'b010) && (f3 != 3'b011);
            end
            7'b0110111: dec.b = imm_u;
            7'b0010111: begin
                dec.a = in_pc;
                dec.b = imm_u;
            end
            7'b1101111: begin
                dec.a   = in_pc;
                dec.b   = XLEN'(4);
                dec.jmp = 1'b1;
                dec.tgt = in_pc + imm_j;
            end
            7'b1100111: begin
                dec.a   = in_pc;
                dec.b   = XLEN'(4);
                dec.jmp = 1'b1;
                dec.tgt = {jalr_sum[XLEN-1:1], 1'b0};
                legal   = (f3 == 3'b000);
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.op  = OP_ADD;
            dec.a   = '0;
            dec.b   = '0;
            dec.br  = 1'b0;
            dec.jmp = 1'b0;
            dec.tgt = '0;
        end
        dec.ill = !legal;
        dec.we  = legal && !dec.br && (rd != 5'd0);
    end

    always_comb begin
        s1_adv   = s1_valid_q & (!s2_valid_q | out_ready);
        in_ready = !flush & (!s1_valid_q | s1_adv);
        accept   = in_valid & in_ready;
        taken    = s1_q.jmp | (s1_q.br & alu_flag);

        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (flush)       s1_valid_d = 1'b0;
        else if (accept) begin
            s1_valid_d = 1'b1;
            s1_d       = dec;
        end else if (s1_adv) s1_valid_d = 1'b0;

        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (s1_adv) begin
            s2_d.pc    = s1_q.pc;
            s2_d.rd    = s1_q.rd;
            s2_d.data  = s1_q.ill ? '0 : alu_result;
            s2_d.we    = s1_q.we;
            s2_d.taken = taken;
            s2_d.tgt   = s1_q.tgt;
            s2_d.ill   = s1_q.ill;
            s2_d.mis   = (CHECK_ALIGN != 0) & taken & s1_q.tgt[1];
        end
        if (flush)          s2_valid_d = 1'b0;
        else if (s1_adv)    s2_valid_d = 1'b1;
        else if (out_ready) s2_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign alu_a          = s1_valid_q ? s1_q.a  : '0;
    assign alu_b          = s1_valid_q ? s1_q.b  : '0;
    assign alu_op         = s1_valid_q ? s1_q.op : OP_ADD;
    assign out_valid      = s2_valid_q;
    assign out_pc         = s2_q.pc;
    assign out_rd_addr    = s2_q.rd;
    assign out_rd_data    = s2_q.data;
    assign out_rd_we      = s2_q.we;
    assign out_br_taken   = s2_q.taken;
    assign out_br_target  = s2_q.tgt;
    assign out_illegal    = s2_q.ill;
    assign out_misaligned = s2_q.mis;
endmodule
